if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined RISC-V core.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched instruction and exposes the decoded fields that feed Controller and ALUController.
- Handles the load-use stall, external stall, and flush on a branch/jump redirect resolved in EX.

Parameters:
- PC_W, 32, width of PC and addresses.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 32'h00000013, instruction presented when the IF/ID slot is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_W  instruction-memory address, equal to the current PC.
- imem_rdata  in  32  instruction at imem_addr, combinational (same-cycle) read.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- ex_target  in  PC_W  redirect target address.
- ex_memread  in  1  instruction currently in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ext_stall  in  1  external hold request (e.g. memory not ready).
- id_valid  out  1  IF/ID slot holds a real instruction.
- id_pc  out  PC_W  PC of the instruction in ID.
- id_instr  out  32  instruction in ID; NOP_INSTR when id_valid=0.
- id_opcode  out  7  id_instr[6:0], to Controller.opcode.
- id_funct3  out  3  id_instr[14:12].
- id_funct7  out  7  id_instr[31:25].
- id_rs1, id_rs2, id_rd  out  5 each  id_instr[19:15], [24:20], [11:7].
- id_bubble  out  1  ID/EX must load a bubble this cycle (Controller outputs forced to 0).

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP_INSTR.
  - id_bubble=0 while reset is asserted.
- Field outputs are combinational slices of id_instr.
- imem_addr is always equal to pc.
- Hazard: lu_hazard = id_valid & ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Per-cycle priority, highest first:
  1. Redirect (ex_redirect=1):
     - pc <= {ex_target[PC_W-1:2],2'b00}; target bits [1:0] are ignored.
     - id_valid <= 0, id_instr <= NOP_INSTR, id_pc <= 0.
     - Wins over stall and hazard in the same cycle.
  2. Hold (lu_hazard | ext_stall):
     - pc and the IF/ID register keep their values.
     - id_bubble=1 (combinational, same cycle).
  3. Advance:
     - pc <= pc+4, wrapping modulo 2^PC_W.
     - id_instr <= imem_rdata, id_pc <= pc, id_valid <= 1.
- id_bubble = (lu_hazard | ext_stall) & ~ex_redirect.
- Latency: the instruction at address A, fetched in cycle n, appears on id_* in cycle n+1.
- Flush penalty on redirect:
  - 1 dead ID cycle (id_valid=0).
  - The target instruction reaches ID 2 cycles after ex_redirect is sampled.
- Load-use stall lasts exactly 1 cycle: the load leaves EX, so lu_hazard drops unless ext_stall persists.
- A load in EX with ex_rd=0 never stalls.
- An empty slot (id_valid=0) never raises lu_hazard.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- When defined, adds output ports perf_stall_cnt (32 bits) and perf_flush_cnt (32 bits):
  - perf_stall_cnt increments each cycle id_bubble=1.
  - perf_flush_cnt increments each cycle ex_redirect=1.
  - Both saturate at 32'hFFFFFFFF and reset asynchronously to 0.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset then free-run, imem word at 0 = 32'h00c50a63 (beq), at 4 = 32'h0072c7b3:
  - Cycle 1: id_pc=0, id_opcode=7'b1100011, id_rs1=10, id_rs2=12.
  - Cycle 2: id_pc=4, id_opcode=7'b0110011.
- Load-use: id_instr=32'h00311733 (rs1=2, rs2=3), ex_memread=1, ex_rd=3:
  - id_bubble=1.
  - pc and id_instr unchanged for 1 cycle, then advance.
  - Repeat with ex_rd=0: no stall.
- Redirect: pc=8, ex_redirect=1, ex_target=32'h0000002B:
  - Next cycle: pc=32'h28, id_valid=0, id_instr=32'h00000013.
  - Cycle after: id_pc=32'h28, id_valid=1.
- Simultaneous ex_redirect=1, ext_stall=1, and a load-use hazard:
  - Redirect wins, id_bubble=0, slot flushed.
- Wrap and async reset: PC_W=8, pc=8'hFC advances to 8'h00.
  - Assert reset mid-cycle during ext_stall=1: pc=0 and id_valid=0 immediately, without waiting for a clock edge.
- With IFID_PERF_CNT_EN: 3 stall cycles plus 2 redirects give perf_stall_cnt=3 and perf_flush_cnt=2.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, applies
// redirect/hold/advance each cycle and exposes decoded fields of the ID instruction.
// Optional macro IFID_PERF_CNT_EN adds saturating stall/flush performance counters.
`timescale 1ns/1ps

module if_id_stage #(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    input  logic            ext_stall,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
`ifdef IFID_PERF_CNT_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    output logic            id_bubble
);

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_REDIRECT
    } action_e;

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redirect_pc;
    logic            lu_hazard;
    logic            hold_req;
    action_e         action;

    assign imem_addr = pc;

    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];
    assign id_rs1    = id_instr[19:15];
    assign id_rs2    = id_instr[24:20];
    assign id_rd     = id_instr[11:7];

    // An empty slot carries NOP_INSTR, so id_valid gates the hazard explicitly.
    assign lu_hazard = id_valid & ex_memread & (ex_rd != 5'd0)
                     & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign hold_req  = lu_hazard | ext_stall;
    assign id_bubble = hold_req & ~ex_redirect & ~reset;

    assign redirect_pc = ex_target & ALIGN_MASK;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        action = ACT_ADVANCE;
        if (ex_redirect) begin
            action = ACT_REDIRECT;
        end else if (hold_req) begin
            action = ACT_HOLD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (action)
                ACT_REDIRECT: pc <= redirect_pc;
                ACT_ADVANCE:  pc <= pc + PC_STEP;
                default:      pc <= pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
        end else begin
            case (action)
                ACT_REDIRECT: begin
                    id_valid <= 1'b0;
                    id_pc    <= '0;
                    id_instr <= NOP_INSTR;
                end
                ACT_ADVANCE: begin
                    id_valid <= 1'b1;
                    id_pc    <= pc;
                    id_instr <= imem_rdata;
                end
                default: begin
                    id_valid <= id_valid;
                    id_pc    <= id_pc;
                    id_instr <= id_instr;
                end
            endcase
        end
    end

`ifdef IFID_PERF_CNT_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (id_bubble && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (ex_redirect && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural fetch/IF-ID model.
`timescale 1ns/1ps

module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ext_stall;

    logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;
    logic        id_valid, id_bubble;
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic [7:0]  imem_addr8, id_pc8, ex_target8;
    logic [31:0] imem_rdata8, id_instr8;
    logic        id_valid8, id_bubble8, ex_redirect8, ex_memread8;
    logic [6:0]  id_opcode8, id_funct78;
    logic [2:0]  id_funct38;
    logic [4:0]  id_rs18, id_rs28, id_rd8, ex_rd8;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt8, perf_flush_cnt8;
`endif

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata  = mem[imem_addr[9:2]];
    assign imem_rdata8 = mem[{2'b00, imem_addr8[7:2]}];

    assign ex_redirect8 = 1'b0;
    assign ex_target8   = 8'h00;
    assign ex_memread8  = 1'b0;
    assign ex_rd8       = 5'd0;

    if_id_stage dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ext_stall(ext_stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
`ifdef IFID_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .id_bubble(id_bubble)
    );

    if_id_stage #(.PC_W(8)) dut8 (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
        .ex_redirect(ex_redirect8), .ex_target(ex_target8),
        .ex_memread(ex_memread8), .ex_rd(ex_rd8), .ext_stall(ext_stall),
        .id_valid(id_valid8), .id_pc(id_pc8), .id_instr(id_instr8),
        .id_opcode(id_opcode8), .id_funct3(id_funct38), .id_funct7(id_funct78),
        .id_rs1(id_rs18), .id_rs2(id_rs28), .id_rd(id_rd8),
`ifdef IFID_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt8), .perf_flush_cnt(perf_flush_cnt8),
`endif
        .id_bubble(id_bubble8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_idpc, m_instr;
    logic        m_valid;
    logic [7:0]  m8_pc, m8_idpc;
    logic        m8_valid;
    longint      m_stall_cnt, m_flush_cnt;

    function automatic logic model_hold();
        logic [4:0] rs1, rs2;
        logic       hz;
        rs1 = m_instr[19:15];
        rs2 = m_instr[24:20];
        hz  = m_valid && ex_memread && (ex_rd != 0) && (ex_rd == rs1 || ex_rd == rs2);
        return hz || ext_stall;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 0; m_valid <= 0; m_idpc <= 0; m_instr <= NOP;
            m_stall_cnt <= 0; m_flush_cnt <= 0;
        end else if (ex_redirect) begin
            m_pc <= (ex_target / 4) * 4;
            m_valid <= 0; m_idpc <= 0; m_instr <= NOP;
            if (m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt <= m_flush_cnt + 1;
        end else if (model_hold()) begin
            if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 1;
        end else begin
            m_instr <= mem[(m_pc % 1024) / 4];
            m_idpc  <= m_pc;
            m_valid <= 1;
            m_pc    <= m_pc + 4;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m8_pc <= 0; m8_valid <= 0; m8_idpc <= 0;
        end else if (!ext_stall) begin
            m8_idpc  <= m8_pc;
            m8_valid <= 1;
            m8_pc    <= 8'((int'(m8_pc) + 4) % 256);
        end
    end

    // Compare process: all outputs are meaningful every cycle, reset included.
    always @(negedge clk) begin
        logic exp_bubble;
        exp_bubble = model_hold() && !ex_redirect && !reset;
        check("imem_addr", imem_addr, m_pc);
        check("id_valid",  id_valid,  m_valid);
        check("id_pc",     id_pc,     m_idpc);
        check("id_instr",  id_instr,  m_instr);
        check("id_opcode", id_opcode, m_instr & 32'h7F);
        check("id_funct3", id_funct3, (m_instr >> 12) & 32'h7);
        check("id_funct7", id_funct7, m_instr >> 25);
        check("id_rs1",    id_rs1,    (m_instr >> 15) & 32'h1F);
        check("id_rs2",    id_rs2,    (m_instr >> 20) & 32'h1F);
        check("id_rd",     id_rd,     (m_instr >> 7) & 32'h1F);
        check("id_bubble", id_bubble, exp_bubble);
        check("imem_addr8", imem_addr8, m8_pc);
        check("id_valid8",  id_valid8,  m8_valid);
        check("id_pc8",     id_pc8,     m8_idpc);
        check("id_bubble8", id_bubble8, ext_stall && !reset);
`ifdef IFID_PERF_CNT_EN
        check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
        check("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ex_redirect = 0; ex_target = 0; ex_memread = 0; ex_rd = 0; ext_stall = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = 32'h00c5_0a63;
        mem[1]  = 32'h0072_c7b3;
        mem[2]  = 32'h0031_1733;
        mem[3]  = 32'h0031_1733;
        mem[10] = 32'h0031_1733;

        idle();
        reset = 1;
        ext_stall = 1;
        #3;
        check("rst_addr",   imem_addr, 32'h0);
        check("rst_valid",  id_valid,  1'b0);
        check("rst_pc",     id_pc,     32'h0);
        check("rst_instr",  id_instr,  NOP);
        check("rst_bubble", id_bubble, 1'b0);
        tick(); tick();
        reset = 0;
        idle();

        // free-run from reset
        tick(); #1;
        check("c1_pc",     id_pc,     32'h0);
        check("c1_opcode", id_opcode, 7'b1100011);
        check("c1_rs1",    id_rs1,    5'd10);
        check("c1_rs2",    id_rs2,    5'd12);
        tick(); #1;
        check("c2_pc",     id_pc,     32'h4);
        check("c2_opcode", id_opcode, 7'b0110011);

        // load-use stall
        tick();
        ex_memread = 1; ex_rd = 5'd3;
        #1 check("lu_bubble", id_bubble, 1'b1);
        tick();
        ex_memread = 0; ex_rd = 0;
        #1;
        check("lu_hold_instr", id_instr,  32'h0031_1733);
        check("lu_hold_addr",  imem_addr, 32'hC);
        check("lu_release",    id_bubble, 1'b0);
        tick(); #1;
        check("lu_adv_pc",   id_pc,     32'hC);
        check("lu_adv_addr", imem_addr, 32'h10);
        ex_memread = 1; ex_rd = 5'd0;
        #1 check("lu_rd0_bubble", id_bubble, 1'b0);
        tick(); #1;
        check("lu_rd0_pc", id_pc, 32'h10);
        ex_memread = 0;

        // redirect
        ex_redirect = 1; ex_target = 32'h8;
        tick();
        ex_target = 32'h2B;
        #1;
        check("rd_pc8",    imem_addr, 32'h8);
        check("rd_valid0", id_valid,  1'b0);
        tick();
        idle();
        #1;
        check("rd_pc28",   imem_addr, 32'h28);
        check("rd_flush",  id_valid,  1'b0);
        check("rd_nop",    id_instr,  NOP);
        tick(); #1;
        check("rd_tgt_pc",    id_pc,     32'h28);
        check("rd_tgt_valid", id_valid,  1'b1);
        check("rd_tgt_instr", id_instr,  32'h0031_1733);

        // redirect beats stall and hazard together
        ex_redirect = 1; ex_target = 32'h40; ext_stall = 1; ex_memread = 1; ex_rd = 5'd2;
        #1 check("all_bubble", id_bubble, 1'b0);
        tick();
        idle();
        #1;
        check("all_addr",  imem_addr, 32'h40);
        check("all_valid", id_valid,  1'b0);
        check("all_instr", id_instr,  NOP);

        // asynchronous reset in the middle of an external stall
        ext_stall = 1;
        tick(); tick(); #1;
        check("stall_hold", imem_addr, 32'h40);
        #1 reset = 1;
        #0.5;
        check("arst_addr",  imem_addr,  32'h0);
        check("arst_valid", id_valid,   1'b0);
        check("arst_addr8", imem_addr8, 8'h00);
        tick();
        reset = 0;
        idle();

        // 8-bit PC wraps from FC to 00
        for (int i = 0; i < 63; i++) tick();
        #1 check("wrap_fc", imem_addr8, 8'hFC);
        tick(); #1;
        check("wrap_00", imem_addr8, 8'h00);
        check("wrap_id", id_pc8,     8'hFC);

`ifdef IFID_PERF_CNT_EN
        reset = 1;
        tick();
        reset = 0;
        ext_stall = 1;
        tick(); tick(); tick();
        ext_stall = 0; ex_redirect = 1; ex_target = 32'h0;
        tick(); tick();
        idle();
        #1;
        check("perf_stall3", perf_stall_cnt, 32'd3);
        check("perf_flush2", perf_flush_cnt, 32'd2);
`endif

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset       = ($urandom_range(0, 199) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            ex_target   = $urandom;
            ext_stall   = ($urandom_range(0, 6) == 0);
            ex_memread  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       ex_rd = m_instr[19:15];
                1:       ex_rd = m_instr[24:20];
                default: ex_rd = 5'($urandom);
            endcase
        end
        tick();
        reset = 0;
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
